// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module  : uart_tx_pkg
// Brief   : Shared types and frame constants for the stdout UART transmitter.
//           Frame length depends on UART_TX_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS_NOPAR = DATA_BITS + 2;
  localparam int FRAME_BITS_PAR   = DATA_BITS + 3;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PAR;
`else
  localparam int FRAME_BITS = FRAME_BITS_NOPAR;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int frame_cycles(input int clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with separate occupancy counter (0..DEPTH).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_stdout.sv
// ============================================================================
// Module  : uart_tx_stdout
// Brief   : FIFO-buffered UART transmitter (8N1, or 8E1 when
//           UART_TX_PARITY_EN is defined) for the stdout pseudo-peripheral.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_stdout
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int         BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic       fifo_full, fifo_empty, pop;
  logic [7:0] fifo_rdata;
  logic       baud_end;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (valid_i && ready_o),
    .wdata_i (data_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign ready_o  = !fifo_full;
  assign tx_o     = tx_q;
  assign busy_o   = (state_q != ST_IDLE) || !fifo_empty;
  assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end

      ST_START: begin
        if (baud_end) begin
          state_d   = ST_DATA;
          baud_d    = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (baud_end) begin
          state_d = ST_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
`else
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
`endif
      end

      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase

    // Popping from IDLE or the end of STOP both launch a new frame, so
    // consecutive frames abut with no idle gap.
    if (pop) begin
      state_d   = ST_START;
      baud_d    = '0;
      bit_idx_d = '0;
      shift_d   = fifo_rdata;
      tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^fifo_rdata;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_stdout.sv
// ============================================================================
// Module  : tb_uart_tx_stdout
// Brief   : Directed self-checking bench for uart_tx_stdout (CLKS_PER_BIT=4,
//           FIFO_DEPTH=8); frame shape follows UART_TX_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_stdout;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] data;
  logic       valid;
  logic       ready_o, tx_o, busy_o;
  logic [3:0] level_o;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] stream [16];
  bit         lvl_track = 1'b0;
  int         lvl_max = 0;
  bit         saw_full;

  uart_tx_stdout #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .data_i  (data),
    .valid_i (valid),
    .ready_o (ready_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .level_o (level_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!lvl_track)                 lvl_max = 0;
    else if (int'(level_o) > lvl_max) lvl_max = int'(level_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level for bit slot idx of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check_frame(input logic [7:0] b);
    for (int k = 0; k < NBITS * CPB; k++) begin
      @(negedge clk);
      check("tx_bit", 32'(tx_o), 32'(exp_bit(b, k / CPB)));
    end
  endtask

  // Called at a negedge; the byte is sampled at the following posedge.
  task automatic push(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic push_stream(input int n);
    int  i = 0;
    int  budget = 2000;
    logic rdy;
    while (i < n && budget > 0) begin
      data  = stream[i];
      valid = 1'b1;
      rdy   = ready_o;
      if (!rdy) begin
        saw_full = 1'b1;
        check("level_when_not_ready", 32'(level_o), 32'(DEPTH));
      end
      @(posedge clk);
      @(negedge clk);
      if (rdy) i++;
      budget--;
    end
    valid = 1'b0;
    check("push_count", 32'(i), 32'(n));
  endtask

  task automatic check_stream(input int n);
    @(negedge clk);
    check("idle_before_start", 32'(tx_o), 32'd1);
    for (int f = 0; f < n; f++) check_frame(stream[f]);
  endtask

  initial begin
    rst_ni = 1'b0;
    valid  = 1'b0;
    data   = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Single byute 'A': line stays high until one edge after the push.
    push(8'h41);
    check("a_tx_idle", 32'(tx_o), 32'd1);
    check("a_level", 32'(level_o), 32'd1);
    check("a_busy", 32'(busy_o), 32'd1);
    check_frame(8'h41);
    check("a_busy_in_stop", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("a_busy_done", 32'(busy_o), 32'd0);
    check("a_tx_done", 32'(tx_o), 32'd1);

    // "OK\n" pushed on consecutive edges: contiguous frames, level peaks at 2.
    stream[0] = 8'h4F; stream[1] = 8'h4B; stream[2] = 8'h0A;
    lvl_track = 1'b1;
    fork
      push_stream(3);
      check_stream(3);
    join
    check("ok_level_peak", 32'(lvl_max), 32'd2);
    lvl_track = 1'b0;
    @(negedge clk);
    check("ok_busy_done", 32'(busy_o), 32'd0);

    // Ten bytes into an 8-deep FIFO: backpressure, then in-order drain.
    for (int i = 0; i < 10; i++) stream[i] = 8'(8'h30 + i * 7);
    saw_full = 1'b0;
    fork
      push_stream(10);
      check_stream(10);
    join
    check("burst_saw_full", 32'(saw_full), 32'd1);
    @(negedge clk);
    check("burst_busy_done", 32'(busy_o), 32'd0);
    check("burst_level_done", 32'(level_o), 32'd0);

    // Asynchronous reset in the middle of the data bits of 0x55.
    push(8'h55);
    push(8'h33);
    repeat (9) @(negedge clk);
    check("pre_rst_tx", 32'(tx_o), 32'd0);
    check("pre_rst_level", 32'(level_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx_o), 32'd1);
    check("async_rst_level", 32'(level_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_ready", 32'(ready_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("post_rst_tx", 32'(tx_o), 32'd1);
    push(8'h0A);
    check_frame(8'h0A);
    @(negedge clk);
    check("post_rst_busy_done", 32'(busy_o), 32'd0);

    // Push landing on the edge where STOP ends with an empty FIFO.
    push(8'h41);
    fork
      begin
        repeat (NBITS * CPB) @(negedge clk);
        push(8'h07);
      end
      begin
        check_frame(8'h41);
        @(negedge clk);
        check("gap_tx_idle", 32'(tx_o), 32'd1);
        check("gap_busy", 32'(busy_o), 32'd1);
        check_frame(8'h07);
      end
    join
    @(negedge clk);
    check("gap_busy_done", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
